floating_point_div_seq: RTL

Iterative IEEE-754 single-precision divider, the inverse of the datapath's combinational floating-point multiplier. It accepts operands `a` and `b` over a valid/ready handshake and computes `a / b` with a restoring mantissa divider, one quotient bit per cycle. It returns the quotient with exception flags through a held output handshake. It sits beside the floating-point ALU as its long-latency division unit.

---
 rtl/fp_div_pkg.sv | 28 ++
 rtl/fp_classify.sv | 25 ++
 rtl/floating_point_div_seq.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/fp_div_pkg.sv
// Shared constants, state encoding and flag bundle for the iterative FP divider.
package fp_div_pkg;

    localparam int EXP_W      = 8;
    localparam int MAN_W      = 23;
    localparam int W          = 1 + EXP_W + MAN_W;
    localparam int SIG_W      = MAN_W + 1;
    localparam int BIAS       = 127;
    localparam int ITERATIONS = 26;

    localparam logic [W-1:0] QNAN    = 32'h7FC0_0000;
    localparam logic [W-1:0] INF_MAG = 32'h7F80_0000;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        NORM,
        DONE
    } state_t;

    typedef struct packed {
        logic overflow;
        logic underflow;
        logic div_zero;
        logic invalid;
    } flags_t;

endpackage

// File: rtl/fp_classify.sv
// Splits one IEEE-754 single operand into fields and classifies it.
// Denormals report as zero, so the divider never sees a significand without its hidden 1.
module fp_classify
    import fp_div_pkg::*;
(
    input  logic [W-1:0]     word,
    output logic             sign,
    output logic [EXP_W-1:0] exponent,
    output logic [SIG_W-1:0] sig,
    output logic             is_zero,
    output logic             is_inf,
    output logic             is_nan
);

    logic [MAN_W-1:0] man;

    assign sign     = word[W-1];
    assign exponent = word[W-2 -: EXP_W];
    assign man      = word[MAN_W-1:0];
    assign sig      = {1'b1, man};
    assign is_zero  = (exponent == '0);
    assign is_inf   = (exponent == '1) && (man == '0);
    assign is_nan   = (exponent == '1) && (man != '0);

endmodule

// File: rtl/floating_point_div_seq.sv
// Iterative single-precision divider: restoring mantissa division, one quotient
// bit per cycle, truncating rounding, result held on a valid/ready output.
module floating_point_div_seq
    import fp_div_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         overflow,
    output logic         underflow,
    output logic         div_zero,
    output logic         invalid
);

    localparam int EXPD_W = EXP_W + 2;
    localparam int CNT_W  = $clog2(ITERATIONS);
    localparam int REM_W  = SIG_W + 2;

    localparam logic signed [EXPD_W-1:0] EXP_BIAS    = EXPD_W'(BIAS);
    localparam logic signed [EXPD_W-1:0] EXP_BIAS_M1 = EXPD_W'(BIAS - 1);
    localparam logic signed [EXPD_W-1:0] EXP_MAX     = EXPD_W'((1 << EXP_W) - 1);
    localparam logic [CNT_W-1:0]         ITER_LAST   = CNT_W'(ITERATIONS - 1);

    state_t state, state_next;

    logic             sign_a, sign_b, zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
    logic [EXP_W-1:0] exp_a, exp_b;
    logic [SIG_W-1:0] sig_a, sig_b;
    logic             sign;

    logic             is_special;
    logic [W-1:0]     special_result;
    flags_t           special_flags;

    logic                     q_sign;
    logic signed [EXPD_W-1:0] exp_diff;
    logic [SIG_W-1:0]         divisor;
    logic [REM_W-1:0]         rem;
    logic [ITERATIONS-1:0]    quot;
    logic [CNT_W-1:0]         iter;
    logic [W-1:0]             pend_result;
    flags_t                   pend_flags;

    logic                     rem_ge;
    logic [REM_W-1:0]         rem_sub;
    logic signed [EXPD_W-1:0] norm_exp;
    logic [MAN_W-1:0]         norm_man;
    logic [W-1:0]             norm_result;
    flags_t                   norm_flags;

    fp_classify u_classify_a (
        .word     (a),
        .sign     (sign_a),
        .exponent (exp_a),
        .sig      (sig_a),
        .is_zero  (zero_a),
        .is_inf   (inf_a),
        .is_nan   (nan_a)
    );

    fp_classify u_classify_b (
        .word     (b),
        .sign     (sign_b),
        .exponent (exp_b),
        .sig      (sig_b),
        .is_zero  (zero_b),
        .is_inf   (inf_b),
        .is_nan   (nan_b)
    );

    assign sign = sign_a ^ sign_b;

    // Special-operand results, checked in priority order; anything else needs the divider.
    always_comb begin
        special_result = '0;
        special_flags  = '0;
        is_special     = 1'b1;
        if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b)) begin
            special_result        = QNAN;
            special_flags.invalid = 1'b1;
        end else if (zero_b && !inf_a) begin
            special_result         = {sign, INF_MAG[W-2:0]};
            special_flags.div_zero = 1'b1;
        end else if (inf_a) begin
            special_result = {sign, INF_MAG[W-2:0]};
        end else if (inf_b || zero_a) begin
            special_result = {sign, {(W-1){1'b0}}};
        end else begin
            is_special = 1'b0;
        end
    end

    // One restoring step: subtract the divisor when it fits, the fit decision is the next quotient bit.
    always_comb begin
        rem_ge  = (rem >= {2'b00, divisor});
        rem_sub = rem_ge ? (rem - {2'b00, divisor}) : rem;
    end

    // Normalize the quotient, range-check the exponent and pack the final word.
    always_comb begin
        norm_flags = '0;
        if (quot[ITERATIONS-1]) begin
            norm_man = quot[ITERATIONS-2 -: MAN_W];
            norm_exp = exp_diff + EXP_BIAS;
        end else begin
            norm_man = quot[ITERATIONS-3 -: MAN_W];
            norm_exp = exp_diff + EXP_BIAS_M1;
        end
        if (norm_exp >= EXP_MAX) begin
            norm_result         = {q_sign, INF_MAG[W-2:0]};
            norm_flags.overflow = 1'b1;
        end else if (norm_exp[EXPD_W-1] || (norm_exp == '0)) begin
            norm_result          = {q_sign, {(W-1){1'b0}}};
            norm_flags.underflow = 1'b1;
        end else begin
            norm_result = {q_sign, norm_exp[EXP_W-1:0], norm_man};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the idle-side handshake.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = is_special ? DONE : DIVIDE;
                end
            end
            DIVIDE: begin
                if (iter == ITER_LAST) begin
                    state_next = NORM;
                end
            end
            NORM: state_next = DONE;
            DONE: begin
                if (out_valid && out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: capture operands on accept, iterate the divider, stage the packed result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_sign      <= 1'b0;
            exp_diff    <= '0;
            divisor     <= '0;
            rem         <= '0;
            quot        <= '0;
            iter        <= '0;
            pend_result <= '0;
            pend_flags  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        q_sign      <= sign;
                        exp_diff    <= $signed({2'b00, exp_a}) - $signed({2'b00, exp_b});
                        divisor     <= sig_b;
                        rem         <= {2'b00, sig_a};
                        quot        <= '0;
                        iter        <= '0;
                        pend_result <= special_result;
                        pend_flags  <= special_flags;
                    end
                end
                DIVIDE: begin
                    rem  <= rem_sub << 1;
                    quot <= {quot[ITERATIONS-2:0], rem_ge};
                    iter <= iter + 1'b1;
                end
                NORM: begin
                    pend_result <= norm_result;
                    pend_flags  <= norm_flags;
                end
                default: ;
            endcase
        end
    end

    // Output register: load the staged result on the first DONE cycle, hold it until consumed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            div_zero  <= 1'b0;
            invalid   <= 1'b0;
        end else if (state == DONE) begin
            if (!out_valid) begin
                out_valid <= 1'b1;
                result    <= pend_result;
                overflow  <= pend_flags.overflow;
                underflow <= pend_flags.underflow;
                div_zero  <= pend_flags.div_zero;
                invalid   <= pend_flags.invalid;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
